// File: rtl/bus_arb_pkg.sv
// Shared encodings for the datapath bus arbiter: FSM states and requester slot indices.
`default_nettype none

package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_TURN = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_IF   = 0;
  localparam int unsigned REQ_ALU  = 1;
  localparam int unsigned REQ_ALUI = 2;
  localparam int unsigned REQ_MLS  = 3;
  localparam int unsigned REQ_MOV  = 4;
  localparam int unsigned REQ_MOVI = 5;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request scanning upward from ptr with wrap.
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [ID_W-1:0]  pick_id_o,
  output logic             any_o
);

  int idx;

  always_comb begin
    pick_o    = '0;
    pick_id_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr_i) + off) % N_REQ;
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        pick_o[idx] = 1'b1;
        pick_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin request/grant/done arbiter with a dead cycle between bus owners.
// Optional forced release of a stuck owner when BUS_ARBITER_TIMEOUT_EN is defined.
`default_nettype none

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int N_REQ    = 8,
  parameter  int MAX_HOLD = 255,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             bus_busy_o,
  output logic             timeout_o,
  output logic [ID_W-1:0]  timeout_id_o
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             owner_done;
  logic             limit_hit;
  logic [ID_W-1:0]  next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .pick_id_o (pick_id),
    .any_o     (pick_any)
  );

  assign owner_done = done_i[grant_id_q];
  assign next_ptr   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        if (pick_any) begin
          grant_d    = pick;
          grant_id_d = pick_id;
          state_d    = ARB_OWN;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          state_d    = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        // done wins over the hold limit, so a same-cycle done is a normal release
        if (owner_done || limit_hit) begin
          grant_d    = '0;
          grant_id_d = '0;
          ptr_d      = next_ptr;
          state_d    = ARB_TURN;
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = ARB_IDLE;
      end
    endcase
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign bus_busy_o = |grant_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
  logic [ID_W-1:0]   timeout_id_q;

  assign limit_hit = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q       <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      if (state_q != ARB_OWN) begin
        hold_q <= '0;
      end else if (!owner_done && limit_hit) begin
        hold_q <= '0;
        if (!timeout_q) begin
          timeout_q    <= 1'b1;
          timeout_id_q <= grant_id_q;
        end
      end else begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;
`else
  logic unused_max_hold;

  assign unused_max_hold = (MAX_HOLD > 0);
  assign limit_hit       = 1'b0;
  assign timeout_o       = 1'b0;
  assign timeout_id_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a reference model.
`default_nettype none

module tb_bus_arbiter;

  localparam int N           = 8;
  localparam int IDW         = 3;
  localparam int TB_MAX_HOLD = 4;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] gid;
  logic           busy;
  logic           to;
  logic [IDW-1:0] to_id;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: current owner (-1 = none), rotation pointer, cycles owned, sticky timeout
  int m_owner;
  int m_ptr;
  int m_cycles;
  bit m_to;
  int m_to_id;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (TB_MAX_HOLD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req),
    .done_i       (done),
    .grant_o      (grant),
    .grant_id_o   (gid),
    .bus_busy_o   (busy),
    .timeout_o    (to),
    .timeout_id_o (to_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_cycles = 0;
    m_to     = 1'b0;
    m_to_id  = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    int o;
    bit rel;
    bit frc;
    frc = 1'b0;
    if (m_owner >= 0) begin
      o   = m_owner;
      rel = d[o];
`ifdef BUS_ARBITER_TIMEOUT_EN
      frc = !rel && (m_cycles >= TB_MAX_HOLD);
`endif
      if (rel || frc) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
        if (frc && !m_to) begin
          m_to    = 1'b1;
          m_to_id = o;
        end
      end else begin
        m_cycles++;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % N]) begin
          m_owner  = (m_ptr + i) % N;
          m_cycles = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".id"},    32'(gid),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".busy"},  32'(busy),  32'(m_owner >= 0));
    check({tag, ".to"},    32'(to),    32'(m_to));
    check({tag, ".to_id"}, 32'(to_id), 32'(m_to_id));
  endtask

  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_model(tag);
  endtask

  // called just after a rising edge; the reset must clear outputs before the next edge
  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    check("rst_async.grant", 32'(grant), 32'd0);
    check("rst_async.id",    32'(gid),   32'd0);
    check("rst_async.busy",  32'(busy),  32'd0);
    check("rst_async.to",    32'(to),    32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req    = '0;
    done   = '0;
    model_reset();
  endtask

  logic [N-1:0] rot_exp [7] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h20, 8'h00, 8'h01};

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    rst_ni = 1'b0;
    req    = '0;
    done   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    check_model("reset");

    // round-robin rotation from ptr=0, each owner releases on its first OWN cycle
    for (int i = 0; i < 7; i++) begin
      d = (i % 2 == 1) ? rot_exp[i-1] : 8'h00;
      step("rot", 8'h23, d);
      check("rot.seq", 32'(grant), 32'(rot_exp[i]));
    end
    step("rot_end", 8'h00, 8'h01);
    step("rot_idle", 8'h00, 8'h00);

    // single requester
    step("single", 8'h04, 8'h00);
    check("single.grant", 32'(grant), 32'h04);
    check("single.id", 32'(gid), 32'd2);
    step("single_rel", 8'h00, 8'h04);
    check("single.dead", 32'(grant), 32'h00);
    step("single_idle", 8'h00, 8'h00);

    // non-owner done and owner req drop are ignored
    step("ign", 8'h08, 8'h00);
    step("ign_done10", 8'h00, 8'h10);
    check("ign.hold", 32'(grant), 32'h08);
    step("ign_hold2", 8'h00, 8'h00);
    check("ign.hold2", 32'(grant), 32'h08);
    step("ign_rel", 8'h00, 8'h08);
    check("ign.rel", 32'(grant), 32'h00);

    // withdrawn request leaves no trace
    step("wd", 8'h02, 8'h00);
    step("wd_req5", 8'h20, 8'h00);
    step("wd_rel", 8'h00, 8'h02);
    step("wd_idle", 8'h00, 8'h00);
    check("wd.never5", 32'(grant), 32'h00);
    step("wd_idle2", 8'h00, 8'h00);

    // reset mid-ownership restarts ptr at 0
    step("rstmid", 8'h08, 8'h00);
    check("rstmid.own", 32'(grant), 32'h08);
    do_reset();
    step("rstmid_after", 8'h01, 8'h00);
    check("rstmid.grant0", 32'(grant), 32'h01);
    step("rstmid_rel", 8'h00, 8'h01);
    step("rstmid_idle", 8'h00, 8'h00);

`ifdef BUS_ARBITER_TIMEOUT_EN
    step("to_grant", 8'h40, 8'h00);
    for (int i = 0; i < 3; i++) step("to_hold", 8'h00, 8'h00);
    check("to.held", 32'(grant), 32'h40);
    step("to_force", 8'h02, 8'h00);
    check("to.cleared", 32'(grant), 32'h00);
    check("to.flag", 32'(to), 32'd1);
    check("to.id", 32'(to_id), 32'd6);
    step("to_next", 8'h02, 8'h00);
    check("to.next", 32'(grant), 32'h02);
    step("to_next_rel", 8'h00, 8'h02);
    step("to_idle", 8'h00, 8'h00);
    do_reset();
    step("nto_grant", 8'h40, 8'h00);
    for (int i = 0; i < 3; i++) step("nto_hold", 8'h00, 8'h00);
    step("nto_done", 8'h00, 8'h40);
    check("nto.flag", 32'(to), 32'd0);
    check("nto.grant", 32'(grant), 32'h00);
`endif

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r = N'($urandom_range(0, 255));
      d = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
      step("rand", r, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
